mux_nx1_arb: RTL and testbench



---
 rtl/mux_nx1_arb.sv | 120 ++++++++++++
 tb/tb_mux_nx1_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_arb.sv
// Purpose : N-channel registered mux; channel picked by `sel` (mode=0) or by
//           internal arbitration (mode=1), one word per cycle into a single output register.
// Latency : 1 cycle from input transfer to out_valid; full throughput with out_ready high.
// Backpr. : in_ready (combinational) is driven only when the output register is empty or
//           draining this cycle; a held word is never disturbed by mode/sel changes.
//
// Build option: define MUX_ARB_RR_EN for round-robin arbitration (search starts at ptr and
// wraps upward). Without it, arbitration is fixed priority (lowest index wins) and the
// round-robin pointer does not exist.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_data/in_valid      CHANNELS packed words (ch c at [c*WIDTH +: WIDTH]) and their valids
//   in_ready              per-channel accept
//   mode, sel             0 = manual (use sel), 1 = arbitrated
//   out_data/out_chan     registered word and the channel that produced it
//   out_valid/out_ready   output handshake
module mux_nx1_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0] ptr;
`endif

  logic                can_load;
  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    grant_data;
  logic                xfer;

  assign can_load = ~out_valid | out_ready;

  // Encoded grant selection. grant_idx is only meaningful when grant_any is set.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      // Out-of-range select (non-power-of-2 CHANNELS) grants nothing.
      if (int'(sel) < CHANNELS) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end else begin
`ifdef MUX_ARB_RR_EN
      // First valid channel at or above ptr, wrapping modulo CHANNELS.
      for (int i = 0; i < CHANNELS; i++) begin
        if (!grant_any && in_valid[(int'(ptr) + i) % CHANNELS]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'((int'(ptr) + i) % CHANNELS);
        end
      end
`else
      // Scan downward so the lowest valid index is the last one written.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
`endif
    end
  end

  // One-hot expansion and data selection without indexing past CHANNELS-1.
  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_any && int'(grant_idx) == c) begin
        grant[c]   = 1'b1;
        grant_data = in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = grant & {CHANNELS{can_load & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Pointer moves only on arbitrated transfers; manual traffic leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && mode) begin
      ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_nx1_arb.sv
module tb_mux_nx1_arb;
  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [C*W-1:0]   in_data;
  logic [C-1:0]     in_valid;
  logic [C-1:0]     in_ready;
  logic             mode;
  logic [1:0]       sel;
  logic [W-1:0]     out_data;
  logic [1:0]       out_chan;
  logic             out_valid;
  logic             out_ready;

  // Second instance with a non-power-of-2 channel count.
  logic [3*W-1:0]   in_data3;
  logic [2:0]       in_valid3;
  logic [2:0]       in_ready3;
  logic             mode3;
  logic [1:0]       sel3;
  logic [W-1:0]     out_data3;
  logic [1:0]       out_chan3;
  logic             out_valid3;
  logic             out_ready3;

  mux_nx1_arb #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nx1_arb #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] chan, input logic [7:0] data);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_chan"}, out_chan, chan);
    check({tag, "_data"}, out_data, data);
  endtask

  localparam logic [C*W-1:0] BASE_DATA = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    logic [1:0] rr_seq [5];
    logic [1:0] rr_pair [4];
    logic [7:0] stream [3];
    rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_pair = '{2'd3, 2'd0, 2'd3, 2'd0};
    stream  = '{8'h11, 8'h22, 8'h33};

    // Reset with every channel requesting.
    rst_n = 1'b0; in_data = BASE_DATA; in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_data3 = {8'hC3, 8'hB2, 8'hA1}; in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_chan", out_chan, 2'd0);
    check("rst_ready", in_ready, 4'b0000);

    // First arbitrated grant after release goes to ch0 in either build.
    rst_n = 1'b1;
    #1;
    check("first_grant", in_ready, 4'b0001);
    check("ch3_sel_oob", in_ready3, 3'b000);

`ifdef MUX_ARB_RR_EN
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rr_all%0d", i), rr_seq[i], BASE_DATA[rr_seq[i]*W +: W]);
    end
    // ptr is 1 here; ch3 wins first, then wrap to 0.
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("rr_pair%0d", i), rr_pair[i], BASE_DATA[rr_pair[i]*W +: W]);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("fp_all%0d", i), 2'd0, 8'h11);
    end
    in_valid = 4'b1110;
    tick();
    check_out("fp_drop0", 2'd1, 8'h22);
    in_valid = 4'b1001;
    tick();
    check_out("fp_pair", 2'd0, 8'h11);
`endif

    // Manual streaming from ch2, no bubbles.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      in_data[2*W +: W] = stream[i];
      #1;
      check($sformatf("man_ready%0d", i), in_ready, 4'b0100);
      tick();
      check_out($sformatf("man%0d", i), 2'd2, stream[i]);
    end
    // Ready without valid: no transfer, register drains.
    in_valid = 4'b0000;
    #1;
    check("man_ready_novalid", in_ready, 4'b0100);
    tick();
    check("man_drain", out_valid, 1'b0);

    // Backpressure: hold 0xA5 from ch1 while mode/sel wander.
    sel = 2'd1; in_valid = 4'b0010; in_data[1*W +: W] = 8'hA5;
    tick();
    check_out("bp_load", 2'd1, 8'hA5);
    out_ready = 1'b0; in_data[1*W +: W] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin mode = 1'b1; sel = 2'd3; in_valid = 4'b1111; end
      #1;
      check($sformatf("bp_ready%0d", i), in_ready, 4'b0000);
      tick();
      check_out($sformatf("bp_hold%0d", i), 2'd1, 8'hA5);
    end
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 4'b0010);
    tick();
    check_out("bp_reload", 2'd1, 8'h5A);

    // Manual transfers must not have moved the pointer.
    in_data = BASE_DATA; mode = 1'b1; in_valid = 4'b1111;
    tick();
`ifdef MUX_ARB_RR_EN
    check_out("ptr_kept", 2'd1, 8'h22);
`else
    check_out("ptr_kept", 2'd0, 8'h11);
`endif

    // Mid-operation reset discards the held word.
    out_ready = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_ready", in_ready, 4'b0000);
    tick();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 8'h00);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", in_ready, 4'b0001);

    // Non-power-of-2 instance: in-range select works.
    sel3 = 2'd2;
    #1;
    check("ch3_sel2_ready", in_ready3, 3'b100);
    tick();
    check("ch3_chan", out_chan3, 2'd2);
    check("ch3_data", out_data3, 8'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
